// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus between fetch_unit (master) and the instruction memory (slave).
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ready bus and forms branch targets.
// Optional FETCH_HALT_ON_ZERO_EN: an all-zero fetched word parks the unit in HALT until reset.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    fetch_unit_if.master      mem,
    output logic [31:0]       Instruction,
    output logic              instr_valid,
    input  logic              instr_ack,
    input  logic              Brtaken,
    input  logic              UncondBr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam int unsigned       IMM26_EXT_W = ADDR_W - 28;
    localparam int unsigned       IMM19_EXT_W = ADDR_W - 21;
    localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);

`ifdef FETCH_HALT_ON_ZERO_EN
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1
    } state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] imm26_off;
    logic [ADDR_W-1:0] imm19_off;
    logic [ADDR_W-1:0] next_pc;

    // Branch offsets are word counts: sign-extend, then scale by 4 by appending two zeros.
    always_comb begin
        imm26_off = {{IMM26_EXT_W{Instruction[25]}}, Instruction[25:0], 2'b00};
        imm19_off = {{IMM19_EXT_W{Instruction[23]}}, Instruction[23:5], 2'b00};
        next_pc   = pc + PC_STEP;
        // An X on Brtaken fails the equality and falls through to sequential flow.
        if (Brtaken == 1'b1) begin
            if (UncondBr == 1'b1) begin
                next_pc = pc + imm26_off;
            end else begin
                next_pc = pc + imm19_off;
            end
        end
    end

    assign mem.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            Instruction  <= '0;
            instr_valid  <= 1'b0;
            mem.imem_req <= 1'b0;
`ifdef FETCH_HALT_ON_ZERO_EN
            halted       <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    // The request register rises one cycle after reset release; accept only once raised.
                    if (mem.imem_req && mem.imem_ready) begin
                        Instruction  <= mem.imem_rdata;
                        mem.imem_req <= 1'b0;
`ifdef FETCH_HALT_ON_ZERO_EN
                        if (mem.imem_rdata == 32'h0) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            instr_valid <= 1'b1;
                        end
`else
                        state       <= ISSUE;
                        instr_valid <= 1'b1;
`endif
                    end else begin
                        mem.imem_req <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (instr_ack) begin
                        pc           <= next_pc;
                        instr_valid  <= 1'b0;
                        mem.imem_req <= 1'b1;
                        state        <= FETCH;
                    end
                end
`ifdef FETCH_HALT_ON_ZERO_EN
                HALT: begin
                    state <= HALT;
                end
`endif
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

`ifndef FETCH_HALT_ON_ZERO_EN
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and issued words are queued as stimulus is driven.
module tb_fetch_unit;

    localparam int unsigned ADDR_W = 64;

    logic              clk;
    logic              reset;
    logic [31:0]       Instruction;
    logic              instr_valid;
    logic              instr_ack;
    logic              Brtaken;
    logic              UncondBr;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] addr_q[$];
    logic [95:0] instr_q[$];

    fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (64'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem         (bus),
        .Instruction (Instruction),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .Brtaken     (Brtaken),
        .UncondBr    (UncondBr),
        .pc          (pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference next-PC: not taken (including X) steps by 4, taken adds the scaled signed immediate.
    function automatic logic [63:0] model_next(input logic [63:0] a, input logic [31:0] w,
                                               input logic bt, input logic ub);
        logic signed [63:0] off;
        if (bt !== 1'b1) return a + 64'd4;
        if (ub === 1'b1) off = $signed(w[25:0]);
        else             off = $signed(w[23:5]);
        return a + (off <<< 2);
    endfunction

    task automatic do_fetch(input int waits, input logic [31:0] word);
        logic [63:0] exp_a;
        exp_a = 64'h0;
        if (addr_q.size() == 0) chk("addr_q_empty", 64'(addr_q.size()), 64'd1);
        else exp_a = addr_q.pop_front();
        chk("fetch_req",   64'(bus.imem_req), 64'd1);
        chk("fetch_addr",  bus.imem_addr, exp_a);
        chk("fetch_pc",    pc, exp_a);
        chk("fetch_valid", 64'(instr_valid), 64'd0);
        chk("fetch_halt",  64'(halted), 64'd0);
        for (int i = 0; i < waits; i++) begin
            bus.imem_ready = 1'b0;
            bus.imem_rdata = $urandom;
            instr_ack      = 1'b1;
            @(negedge clk);
            chk("wait_req",   64'(bus.imem_req), 64'd1);
            chk("wait_addr",  bus.imem_addr, exp_a);
            chk("wait_valid", 64'(instr_valid), 64'd0);
        end
        instr_ack      = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        instr_q.push_back({exp_a, word});
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = $urandom;
    endtask

    task automatic do_issue(input int delay, input logic bt, input logic ub);
        logic [95:0] e;
        e = 96'h0;
        if (instr_q.size() == 0) chk("instr_q_empty", 64'(instr_q.size()), 64'd1);
        else e = instr_q.pop_front();
        chk("issue_valid", 64'(instr_valid), 64'd1);
        chk("issue_req",   64'(bus.imem_req), 64'd0);
        chk("issue_instr", 64'(Instruction), 64'(e[31:0]));
        chk("issue_pc",    pc, e[95:32]);
        for (int i = 0; i < delay; i++) begin
            instr_ack      = 1'b0;
            bus.imem_ready = 1'b1;
            @(negedge clk);
            chk("hold_valid", 64'(instr_valid), 64'd1);
            chk("hold_instr", 64'(Instruction), 64'(e[31:0]));
            chk("hold_pc",    pc, e[95:32]);
        end
        bus.imem_ready = 1'b0;
        instr_ack      = 1'b1;
        Brtaken        = bt;
        UncondBr       = ub;
        addr_q.push_back(model_next(e[95:32], e[31:0], bt, ub));
        @(negedge clk);
        instr_ack = 1'b0;
        Brtaken   = 1'b0;
        UncondBr  = 1'b0;
    endtask

    task automatic step(input int waits, input logic [31:0] word, input int delay,
                        input logic bt, input logic ub);
        do_fetch(waits, word);
        do_issue(delay, bt, ub);
    endtask

    task automatic release_reset();
        addr_q.delete();
        instr_q.delete();
        addr_q.push_back(64'h0);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] word8;
        logic [95:0] e;
`ifdef FETCH_HALT_ON_ZERO_EN
        word8 = 32'h91000400;
`else
        word8 = 32'h0;
`endif
        reset          = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        instr_ack      = 1'b0;
        Brtaken        = 1'b0;
        UncondBr       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req",   64'(bus.imem_req), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_pc",    pc, 64'h0);
        chk("rst_instr", 64'(Instruction), 64'd0);
        chk("rst_halt",  64'(halted), 64'd0);
        release_reset();

        step(0, 32'h8B020020, 0, 1'b0, 1'b0);   // 0x00 -> 0x04
        step(0, 32'hD1000421, 0, 1'b0, 1'b0);   // 0x04 -> 0x08
        step(0, word8,        0, 1'b0, 1'b0);   // 0x08 -> 0x0C
        step(0, 32'hAA0103E0, 0, 1'b0, 1'b0);   // 0x0C -> 0x10
        step(3, 32'hF9400020, 2, 1'b0, 1'b0);   // memory wait, delayed ack
        step(0, 32'h8B000000, 0, 1'b0, 1'b0);   // 0x14
        step(0, 32'h8B000000, 0, 1'b0, 1'b0);   // 0x18
        step(0, 32'h8B000000, 0, 1'b0, 1'b0);   // 0x1C
        step(0, 32'h17FFFFFC, 0, 1'b1, 1'b1);   // 0x20 -> 0x10 (Imm26=-4)
        step(0, 32'h54000180, 0, 1'b1, 1'b0);   // 0x10 -> 0x40 (Imm19=12)
        step(0, 32'h54000060, 0, 1'b0, 1'b0);   // 0x40 -> 0x44 not taken
        step(0, 32'h54FFFFE0, 0, 1'b1, 1'b0);   // 0x44 -> 0x40 (Imm19=-1)
        step(1, 32'h54000060, 0, 1'b1, 1'b0);   // 0x40 -> 0x4C taken
        step(0, 32'h8B000000, 0, 1'bx, 1'b1);   // 0x4C -> 0x50, X treated as not taken
        step(0, 32'h17FFFFEB, 0, 1'b1, 1'b1);   // 0x50 -> 2^64-4
        step(0, 32'h8B000000, 0, 1'b0, 1'b1);   // wrap to 0
        step(0, 32'h8B000000, 0, 1'b0, 1'b0);   // 0x00 -> 0x04

        // Reset while issuing at 0x04 with ack held low.
        do_fetch(0, 32'hCAFE0001);
        e = instr_q.pop_front();
        chk("pre_rst_valid", 64'(instr_valid), 64'd1);
        chk("pre_rst_pc",    pc, e[95:32]);
        instr_ack = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(instr_valid), 64'd0);
        chk("mid_rst_pc",    pc, 64'h0);
        chk("mid_rst_req",   64'(bus.imem_req), 64'd0);
        chk("mid_rst_instr", 64'(Instruction), 64'd0);
        release_reset();
        step(0, 32'h8B000000, 0, 1'b0, 1'b0);   // 0x00 -> 0x04

`ifdef FETCH_HALT_ON_ZERO_EN
        step(0, 32'h8B000000, 0, 1'b0, 1'b0);   // 0x04 -> 0x08
        do_fetch(0, 32'h0);
        instr_q.delete();
        for (int i = 0; i < 4; i++) begin
            bus.imem_ready = 1'b1;
            instr_ack      = 1'b1;
            chk("halt_flag",  64'(halted), 64'd1);
            chk("halt_req",   64'(bus.imem_req), 64'd0);
            chk("halt_valid", 64'(instr_valid), 64'd0);
            chk("halt_pc",    pc, 64'h8);
            chk("halt_instr", 64'(Instruction), 64'd0);
            @(negedge clk);
        end
`else
        do_fetch(0, 32'h8B000000);
        chk("no_halt", 64'(halted), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control decoder in the single-instruction CPU. Holds the program counter, requests each instruction from a variable-latency instruction memory through a req/ready handshake, and presents the fetched word to decode and execute. Consumes the decoder's `Brtaken` and `UncondBr` to form the next PC from the instruction's Imm26 or Imm19 field.

## Interface
- `ADDR_W`, default 64: PC and instruction-address width.
- `RESET_PC`, default 0: PC value loaded on reset. Must be a multiple of 4.

- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `imem_req`, output, 1: fetch request to instruction memory.
- `imem_addr`, output, `ADDR_W`: fetch address. Always equals `pc`.
- `imem_ready`, input, 1: memory accepts the request and returns `imem_rdata` in this same cycle.
- `imem_rdata`, input, 32: instruction word. Sampled only when `imem_req & imem_ready`.
- `Instruction`, output, 32: registered instruction, fed to decode.
- `instr_valid`, output, 1: `Instruction` is valid and is being executed.
- `instr_ack`, input, 1: execute completed this cycle. `Brtaken` and `UncondBr` are valid in this cycle.
- `Brtaken`, input, 1: branch taken, from decode.
- `UncondBr`, input, 1: 1 selects Imm26, 0 selects Imm19.
- `pc`, output, `ADDR_W`: address of the current or pending instruction.
- `halted`, output, 1: the fetch unit has stopped. Present only with `FETCH_HALT_ON_ZERO_EN`; otherwise tied to 0.

## Operation
- **FSM states:** FETCH, ISSUE, and HALT (HALT exists only when the macro is defined).
- **Reset** (sampled `reset==0`) sets:
  - state to FETCH
  - `pc` to `RESET_PC`
  - `Instruction` to 0
  - `instr_valid`, `imem_req` and `halted` to 0
  - `imem_req` is held at 0 while in reset.
- **FETCH:**
  - Drive `imem_req=1` and `imem_addr=pc`. Both are held stable until `imem_ready`.
  - On `imem_ready`: latch `imem_rdata` into `Instruction` and go to ISSUE.
  - Without `imem_ready`: remain in FETCH, no limit on wait time.
- **ISSUE:**
  - Drive `instr_valid=1` and `imem_req=0`. `Instruction` and `pc` are held stable.
  - On `instr_ack`, update `pc` and go to FETCH:
    - `Brtaken!==1`: `pc <= pc + 4`.
    - `Brtaken==1 & UncondBr==1`: `pc <= pc + (SignExtend(Instruction[25:0]) << 2)`.
    - `Brtaken==1 & UncondBr!=1`: `pc <= pc + (SignExtend(Instruction[23:5]) << 2)`.
  - An X on `Brtaken` is treated as not taken.
- **Arithmetic:**
  - Offsets are sign-extended to `ADDR_W` before the shift.
  - All additions wrap modulo 2^`ADDR_W`; no overflow detection.
  - `pc[1:0]` remains 0.
- **Ignored inputs:**
  - `instr_ack` is ignored outside ISSUE.
  - `imem_ready` is ignored outside FETCH.

## Timing
- Minimum of 2 cycles per instruction: FETCH with `imem_ready` in the same cycle, then ISSUE with `instr_ack` in the same cycle.
- `imem_req` first rises in the first cycle after `reset` deasserts.
- `Instruction` and `instr_valid` are valid the cycle after the accepted fetch.
- The new `pc` is visible the cycle after `instr_ack`, and is also the next `imem_addr`.
- Each additional memory wait cycle or ack delay cycle adds one cycle to the instruction.
- Reset asserted mid-FETCH or mid-ISSUE aborts the operation. No pending request survives; the next fetch is from `RESET_PC`.

## Configuration
- `FETCH_HALT_ON_ZERO_EN` defined:
  - If `imem_rdata==32'h0` when accepted in FETCH, go to HALT instead of ISSUE.
  - In HALT: `halted=1`, `imem_req=0`, `instr_valid=0`, `pc` frozen at the zero word's address, `Instruction` = 0.
  - HALT is left only by reset.
- Macro undefined:
  - No HALT state; `halted` is constant 0.
  - A zero word is issued like any other instruction.

## Test plan
- **Reset and sequential flow:**
  - Stimulus: `RESET_PC=0`, `imem_ready` tied 1, `instr_ack` tied 1, `Brtaken=0`.
  - Required: `imem_addr` sequence 0, 4, 8, 12, one new address every 2 cycles; `instr_valid` alternates 0/1.
- **Memory wait:**
  - Stimulus: hold `imem_ready=0` for 3 cycles at `pc=0x10`.
  - Required: `imem_req=1` and `imem_addr=0x10` stable for 4 cycles; `Instruction` latched in the 4th cycle.
- **Unconditional branch:**
  - Stimulus: at `pc=0x20`, `Instruction=32'h17FFFFFC` (Imm26=-4), ack with `Brtaken=1`, `UncondBr=1`.
  - Required: next `pc=0x10`.
- **Conditional branch:**
  - Stimulus: at `pc=0x40`, `Instruction[23:5]=19'd3`, ack with `Brtaken=1`, `UncondBr=0`.
  - Required: next `pc=0x4C`.
  - Same stimulus with `Brtaken=0`: required next `pc=0x44`.
- **Wrap-around and reset mid-operation:**
  - Stimulus: `pc=2^ADDR_W-4`, not taken.
  - Required: next `pc=0`.
  - Stimulus: assert reset during ISSUE with ack held low.
  - Required: next cycle `instr_valid=0`, `pc=RESET_PC`.
- **Halt on zero** (build with the macro):
  - Stimulus: `imem_rdata=0` at `pc=0x8`.
  - Required: `halted=1`, `imem_req=0` permanently, `pc=0x8`.
  - Same stimulus without the macro: required ISSUE with `Instruction=0`, then `pc=0xC`.
